blk4x4_packer: RTL

BLK4X4_PACKER -- requirements
Module: blk4x4_packer

---
 rtl/h264_pkg.sv | 19 +
 rtl/mb_pos_counter.sv | 55 +++++
 rtl/blk4x4_packer.sv | 83 ++++++++
 3 files changed

// File: rtl/h264_pkg.sv
// Shared definitions for the luma 4x4 block packer: pixel width default,
// block size, packer FSM states and a width helper for position counters.
package h264_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int BLK_PIX   = 16;
  localparam int BLK_IDX_W = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  // Counter width for a range of n values; a single-value range still gets one bit
  function automatic int pos_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mb_pos_counter.sv
// Tracks where the current 4x4 block sits in the frame: block index inside
// the macroblock, then macroblock column and row. One step per block handshake.
module mb_pos_counter
  import h264_pkg::*;
#(
  parameter int FRAME_MB_W = 20,
  parameter int FRAME_MB_H = 15,
  localparam int XW = pos_w(FRAME_MB_W),
  localparam int YW = pos_w(FRAME_MB_H)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 step,
  output logic [BLK_IDX_W-1:0] blk_idx,
  output logic [XW-1:0]        mb_x,
  output logic [YW-1:0]        mb_y,
  output logic                 at_last
);

  localparam logic [BLK_IDX_W-1:0] IDX_LAST = BLK_IDX_W'(BLK_PIX - 1);
  localparam logic [XW-1:0]        X_LAST   = XW'(FRAME_MB_W - 1);
  localparam logic [YW-1:0]        Y_LAST   = YW'(FRAME_MB_H - 1);

  // Advance block index, carrying into column and then row; reset and frame restart both zero everything
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      blk_idx <= '0;
      mb_x    <= '0;
      mb_y    <= '0;
    end else if (step) begin
      if (blk_idx == IDX_LAST) begin
        blk_idx <= '0;
        if (mb_x == X_LAST) begin
          mb_x <= '0;
          if (mb_y == Y_LAST) begin
            mb_y <= '0;
          end else begin
            mb_y <= mb_y + YW'(1);
          end
        end else begin
          mb_x <= mb_x + XW'(1);
        end
      end else begin
        blk_idx <= blk_idx + BLK_IDX_W'(1);
      end
    end
  end

  // Final block of the frame is the last index of the bottom-right macroblock
  always_comb begin
    at_last = (blk_idx == IDX_LAST) && (mb_x == X_LAST) && (mb_y == Y_LAST);
  end

endmodule

// File: rtl/blk4x4_packer.sv
// Collects 16 block-scan luma pixels from the FIFO read side into one packed
// 4x4 block, holds it until the intra predictor takes it, and tags it with
// its position in the frame.
module blk4x4_packer
  import h264_pkg::*;
#(
  parameter int PIX_W      = PIX_W_DEF,
  parameter int FRAME_MB_W = 20,
  parameter int FRAME_MB_H = 15,
  localparam int XW = pos_w(FRAME_MB_W),
  localparam int YW = pos_w(FRAME_MB_H)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sync_i,
  input  logic [PIX_W-1:0]         pix_data_i,
  input  logic                     pix_valid_i,
  output logic                     pix_ready_o,
  output logic [BLK_PIX*PIX_W-1:0] blk_data_o,
  output logic                     blk_valid_o,
  input  logic                     blk_ready_i,
  output logic [BLK_IDX_W-1:0]     blk_idx_o,
  output logic [XW-1:0]            mb_x_o,
  output logic [YW-1:0]            mb_y_o,
  output logic                     last_blk_o
);

  localparam logic [3:0] CNT_LAST = 4'(BLK_PIX - 1);

  pack_state_e              state;
  logic [3:0]               pix_cnt;
  logic [BLK_PIX*PIX_W-1:0] blk_data;
  logic                     blk_step;
  logic                     at_last;

  // Fill/hold FSM with the pixel slot counter and the block assembly register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      pix_cnt  <= '0;
      blk_data <= '0;
    end else if (sync_i) begin
      state   <= FILL;
      pix_cnt <= '0;
    end else if (state == FILL) begin
      if (pix_valid_i) begin
        blk_data[pix_cnt*PIX_W +: PIX_W] <= pix_data_i;
        pix_cnt <= pix_cnt + 4'd1;
        if (pix_cnt == CNT_LAST) begin
          state <= HOLD;
        end
      end
    end else begin
      if (blk_ready_i) begin
        state <= FILL;
      end
    end
  end

  // Handshake flags come from the state alone so the FIFO never sees a path from its own valid
  always_comb begin
    pix_ready_o = (state == FILL);
    blk_valid_o = (state == HOLD);
    blk_step    = (state == HOLD) && blk_ready_i;
    last_blk_o  = (state == HOLD) && at_last;
    blk_data_o  = blk_data;
  end

  mb_pos_counter #(
    .FRAME_MB_W (FRAME_MB_W),
    .FRAME_MB_H (FRAME_MB_H)
  ) u_pos (
    .clk     (clk),
    .rst     (rst),
    .clear   (sync_i),
    .step    (blk_step),
    .blk_idx (blk_idx_o),
    .mb_x    (mb_x_o),
    .mb_y    (mb_y_o),
    .at_last (at_last)
  );

endmodule
